// File: rtl/encrypt_dispatch.sv
// Nonce-search sequencer: issues {header,nonce} to the encrypt pipeline, matches returned digests to in-order tags.
// enc_read 1 cycle after start, found_valid 1 cycle after the hitting enc_write; a pending hit holds until found_ready.
module encrypt_dispatch #(
  parameter int DIGEST_BITS  = 256,
  parameter int NONCE_BITS   = 32,
  parameter int ISSUE_GAP    = 10,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [DIGEST_BITS-NONCE_BITS-1:0] header,
  input  logic [NONCE_BITS-1:0]             nonce_start,
  input  logic [NONCE_BITS-1:0]             nonce_end,
  input  logic [DIGEST_BITS-1:0]            target,
  output logic [DIGEST_BITS-1:0]            enc_in,
  output logic                              enc_read,
  input  logic [DIGEST_BITS-1:0]            enc_out,
  input  logic                              enc_write,
  output logic                              found_valid,
  output logic [NONCE_BITS-1:0]             found_nonce,
  output logic [DIGEST_BITS-1:0]            found_digest,
  input  logic                              found_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              exhausted,
  output logic                              err
);

  localparam int HDR_BITS = DIGEST_BITS - NONCE_BITS;
  localparam int PTR_BITS = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CNT_BITS = $clog2(MAX_INFLIGHT + 1);
  localparam int GAP_BITS = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GAP_BITS-1:0] GAP_RELOAD = GAP_BITS'(ISSUE_GAP - 1);
  localparam logic [CNT_BITS-1:0] MAX_CNT    = CNT_BITS'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state;
  logic [HDR_BITS-1:0]     header_q;
  logic [NONCE_BITS-1:0]   nonce_end_q;
  logic [NONCE_BITS-1:0]   nonce_ctr;
  logic [DIGEST_BITS-1:0]  target_q;
  logic [GAP_BITS-1:0]     gap;
  logic [NONCE_BITS-1:0]   tag_mem [2**PTR_BITS];
  logic [PTR_BITS-1:0]     wr_ptr;
  logic [PTR_BITS-1:0]     rd_ptr;
  logic [CNT_BITS-1:0]     inflight;

  logic                    launch;
  logic                    pop;
  logic                    orphan;
  logic                    hit;
  logic                    issue;
  logic                    last;
  logic [HDR_BITS-1:0]     hdr_sel;
  logic [NONCE_BITS-1:0]   nonce_sel;
  logic [NONCE_BITS-1:0]   end_sel;

  // The first nonce goes out on the start edge itself, straight from the input ports.
  assign launch    = (state == IDLE) && start;
  assign hdr_sel   = launch ? header      : header_q;
  assign nonce_sel = launch ? nonce_start : nonce_ctr;
  assign end_sel   = launch ? nonce_end   : nonce_end_q;
  assign last      = (nonce_sel == end_sel);

  assign pop    = enc_write && (inflight != '0);
  assign orphan = enc_write && (inflight == '0);
  assign hit    = pop && (state == ISSUE) && !found_valid && !abort && (enc_out < target_q);
  assign issue  = launch ||
                  ((state == ISSUE) && (gap == '0) && (inflight < MAX_CNT) && !abort && !hit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      header_q     <= '0;
      nonce_end_q  <= '0;
      nonce_ctr    <= '0;
      target_q     <= '0;
      gap          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inflight     <= '0;
      enc_in       <= '0;
      enc_read     <= 1'b0;
      found_valid  <= 1'b0;
      found_nonce  <= '0;
      found_digest <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      exhausted    <= 1'b0;
      err          <= 1'b0;
    end else begin
      enc_read <= issue;
      done     <= 1'b0;

      if (issue) begin
        enc_in          <= {hdr_sel, nonce_sel};
        tag_mem[wr_ptr] <= nonce_sel;
        wr_ptr          <= wr_ptr + 1'b1;
        nonce_ctr       <= nonce_sel + 1'b1;
        gap             <= GAP_RELOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;
      inflight <= inflight + CNT_BITS'(issue) - CNT_BITS'(pop);

      if (found_valid && found_ready) found_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            header_q    <= header;
            nonce_end_q <= nonce_end;
            target_q    <= target;
            exhausted   <= last;
            err         <= 1'b0;
            busy        <= 1'b1;
            state       <= last ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue && last) begin
            exhausted <= 1'b1;
            state     <= DRAIN;
          end else if (abort || hit) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((inflight == '0) && !found_valid) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (hit) begin
        found_valid  <= 1'b1;
        found_nonce  <= tag_mem[rd_ptr];
        found_digest <= enc_out;
        exhausted    <= 1'b0;
      end

      // Results with no matching tag are dropped; flag them even if start clears err this cycle.
      if (orphan) err <= 1'b1;
    end
  end

endmodule

// File: doc/encrypt_dispatch.md
Name: encrypt_dispatch

Overview:
- Sequences the encrypt pipeline for a nonce search.
- Builds each input word as {header, nonce} and issues it on the encrypt read strobe, no faster than the pipeline's throughput.
- Tracks in-flight nonces in an in-order tag FIFO and compares each returned digest against a target.
- Reports the first hit through a valid/ready handshake; sits between the host control registers and the encrypt module.

Parameters:
DIGEST_BITS, 256, width of the encrypt input/output word
NONCE_BITS, 32, width of the nonce field (low bits of the encrypt input)
ISSUE_GAP, 10, minimum cycles between read strobes; equals the encrypt THROUGHPUT; must be >=1
MAX_INFLIGHT, 8, tag FIFO depth; power of two; must be >= the encrypt pipeline latency divided by ISSUE_GAP

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  pulse; begin a search (ignored unless idle)
abort  in  1  pulse; stop issuing, drain, finish without reporting new hits
header  in  DIGEST_BITS-NONCE_BITS  fixed upper field, latched on start
nonce_start  in  NONCE_BITS  first nonce, latched on start
nonce_end  in  NONCE_BITS  last nonce (inclusive), latched on start
target  in  DIGEST_BITS  hit threshold, latched on start
enc_in  out  DIGEST_BITS  to encrypt in
enc_read  out  1  to encrypt read; one-cycle issue strobe
enc_out  in  DIGEST_BITS  from encrypt out
enc_write  in  1  from encrypt write; result valid
found_valid  out  1  hit available
found_nonce  out  NONCE_BITS  nonce of the hit
found_digest  out  DIGEST_BITS  digest of the hit
found_ready  in  1  consumer accepts the hit
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on entry to IDLE from DONE
exhausted  out  1  sticky; nonce_end was issued without a hit; cleared on start
err  out  1  sticky; enc_write arrived with an empty FIFO; cleared on start

Behaviour:
- Reset, synchronous on rst_n=0:
  - state=IDLE.
  - enc_read, found_valid, busy, done, exhausted and err are 0.
  - enc_in, found_nonce and found_digest are 0.
  - FIFO is empty, inflight=0, gap counter=0.
- Reset mid-search discards all tags. Later enc_write pulses from the still-running pipeline are orphans: they are dropped and set err.
- States are IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start latches header, nonce_start, nonce_end and target.
  - start also loads nonce_ctr=nonce_start and clears exhausted and err.
  - Next state is ISSUE.
- ISSUE:
  - An issue occurs when gap==0, inflight<MAX_INFLIGHT, abort=0 and there is no hit this cycle.
  - On issue, the registered outputs are enc_read=1 and enc_in={header, nonce_ctr}. nonce_ctr is pushed to the FIFO.
  - On issue, gap reloads to ISSUE_GAP-1 and nonce_ctr increments modulo 2^NONCE_BITS (wrap 0xFFFFFFFF->0 is legal).
  - Between issues, gap decrements to 0. enc_read is low on every non-issue cycle, so with ISSUE_GAP=1 it can be high on consecutive cycles.
  - If the issued nonce equals nonce_end: set exhausted and go to DRAIN. A single-nonce range (start==end) issues exactly once.
  - abort or a hit goes to DRAIN.
- Result path (any state, on enc_write):
  - Pop the FIFO head and pair it with enc_out; results return in issue order.
  - Hit = enc_out < target, unsigned full-width compare. A hit counts only in ISSUE, when found_valid=0 and no abort has been seen.
  - On a hit, the next cycle has found_valid=1 with found_nonce and found_digest captured, and the state moves to DRAIN. exhausted is cleared if it was set in the same cycle.
  - Later results are popped and discarded.
- Simultaneous issue and enc_write in one cycle: push and pop together, inflight unchanged, no overflow or underflow.
- A hit takes priority over issue in the same cycle: no issue occurs that cycle.
- found handshake:
  - found_valid holds, with data stable, until a cycle where found_valid&&found_ready; it clears the next cycle.
  - abort never clears a pending found_valid.
- DRAIN: no issue. When inflight==0 and found_valid==0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy drops in the same cycle done rises.
- start outside IDLE is ignored. abort in IDLE is ignored.
- Latency: enc_read rises 1 cycle after the start pulse. found_valid rises 1 cycle after the hitting enc_write.

Test Plan:
1. ISSUE_GAP=10, nonce_start=5, nonce_end=7, target=0 -> three enc_read pulses exactly 10 cycles apart with nonces 5,6,7 in enc_in low bits; no hit; exhausted=1; done pulses after the third enc_write; busy=0 after.
2. Model digest=nonce, target=0x...0 except the 3rd-result digest below target, range 100..199 -> found_nonce=102; no issue after the hit cycle; trailing results discarded; done only after found_ready handshake and inflight==0.
3. ISSUE_GAP=1, MAX_INFLIGHT=8, pipeline latency 20 -> at most 8 consecutive issues, then a stall; inflight never exceeds 8; issue resumes the cycle after the first enc_write; no FIFO overflow.
4. nonce_start=0xFFFFFFFE, nonce_end=0x00000001 -> issues FFFFFFFE, FFFFFFFF, 0, 1, then DRAIN; exhausted=1.
5. abort mid-run with 3 in flight, one of them a hit -> issue stops immediately; found_valid stays 0; done follows the 3rd enc_write.
6. rst_n=0 for 1 cycle with 4 in flight -> all outputs at reset values; the 4 late enc_write pulses set err=1 and are otherwise ignored; the next start clears err and runs normally.
